// File: rtl/mips_hazard_unit.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline: tracks the
// destination/source fields of the EX, MEM and WB stages and derives bypass selects, stalls and flushes.
module mips_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned FWD_EN     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_regwr,
  input  logic              id_load,
  input  logic              ex_taken,
  input  logic              mem_wait,
  output logic              stall,
  output logic              flush_id,
  output logic              ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              wb_regwr,
  output logic [REG_AW-1:0] wb_dst
);

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] dst;
    logic              use_rs;
    logic              use_rt;
    logic              regwr;
    logic              load;
  } ent_t;

  // p0 = EX, p1 = MEM, p2 = WB
  logic vld_p0_q, vld_p0_d;
  logic vld_p1_q, vld_p1_d;
  logic vld_p2_q, vld_p2_d;
  ent_t ent_p0_q, ent_p0_d;
  ent_t ent_p1_q, ent_p1_d;
  ent_t ent_p2_q, ent_p2_d;

  ent_t id_ent;
  logic id_hit_ex, id_hit_mem, id_hit_wb;
  logic load_use, raw_any, hazard, taken_flush;

  // A stage supplies register r only if it really writes it; r0 never matches.
  function automatic logic hit(input logic vld, input ent_t e, input logic [REG_AW-1:0] r);
    return vld && e.regwr && (e.dst == r) && (e.dst != '0);
  endfunction

  function automatic logic id_hits(input logic vld, input ent_t e,
                                   input logic use_rs, input logic [REG_AW-1:0] rs,
                                   input logic use_rt, input logic [REG_AW-1:0] rt);
    return (use_rs && hit(vld, e, rs)) || (use_rt && hit(vld, e, rt));
  endfunction

  // Bypass source for one EX operand: MEM (non-load) beats WB.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_AW-1:0] r,
                                         input logic mem_vld, input ent_t mem_e,
                                         input logic wb_vld, input ent_t wb_e);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_src) begin
      if (hit(mem_vld, mem_e, r) && !mem_e.load) begin
        sel = 2'd1;
      end else if (hit(wb_vld, wb_e, r)) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  always_comb begin
    id_ent = '{rs: id_rs, rt: id_rt, dst: id_dst, use_rs: id_use_rs,
               use_rt: id_use_rt, regwr: id_regwr, load: id_load};

    id_hit_ex  = id_hits(vld_p0_q, ent_p0_q, id_use_rs, id_rs, id_use_rt, id_rt);
    id_hit_mem = id_hits(vld_p1_q, ent_p1_q, id_use_rs, id_rs, id_use_rt, id_rt);
    id_hit_wb  = id_hits(vld_p2_q, ent_p2_q, id_use_rs, id_rs, id_use_rt, id_rt);

    load_use    = id_valid && ent_p0_q.load && id_hit_ex;
    raw_any     = id_valid && (id_hit_ex || id_hit_mem || id_hit_wb);
    hazard      = (FWD_EN != 0) ? load_use : raw_any;
    taken_flush = (DELAY_SLOT == 0) && ex_taken;
  end

  // Freeze dominates, then a taken-transfer squash, then a data-hazard stall.
  always_comb begin
    stall     = 1'b0;
    flush_id  = 1'b0;
    ex_bubble = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        stall = 1'b1;
      end else if (taken_flush) begin
        flush_id  = 1'b1;
        ex_bubble = 1'b1;
      end else if (hazard) begin
        stall     = 1'b1;
        ex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (!rst && (FWD_EN != 0) && vld_p0_q) begin
      fwd_a = fwd_sel(ent_p0_q.use_rs, ent_p0_q.rs, vld_p1_q, ent_p1_q, vld_p2_q, ent_p2_q);
      fwd_b = fwd_sel(ent_p0_q.use_rt, ent_p0_q.rt, vld_p1_q, ent_p1_q, vld_p2_q, ent_p2_q);
    end
    wb_regwr = !rst && vld_p2_q && ent_p2_q.regwr;
    wb_dst   = rst ? '0 : ent_p2_q.dst;
  end

  always_comb begin
    vld_p0_d = vld_p0_q;
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    ent_p0_d = ent_p0_q;
    ent_p1_d = ent_p1_q;
    ent_p2_d = ent_p2_q;
    if (!mem_wait) begin
      // MEM -> WB
      vld_p2_d = vld_p1_q;
      ent_p2_d = ent_p1_q;
      // EX -> MEM
      vld_p1_d = vld_p0_q;
      ent_p1_d = ent_p0_q;
      // ID -> EX, or an empty slot when a bubble is inserted
      if (ex_bubble) begin
        vld_p0_d = 1'b0;
        ent_p0_d = '0;
      end else begin
        vld_p0_d = id_valid;
        ent_p0_d = id_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      ent_p0_q <= '0;
      ent_p1_q <= '0;
      ent_p2_q <= '0;
    end else begin
      vld_p0_q <= vld_p0_d;
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      ent_p0_q <= ent_p0_d;
      ent_p1_q <= ent_p1_d;
      ent_p2_q <= ent_p2_d;
    end
  end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// Scoreboard bench for mips_hazard_unit: three instances (default, DELAY_SLOT=0,
// FWD_EN=0) share the stimulus; the driver queues expected outputs, a monitor checks them.
module tb_mips_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwr, id_load;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       ex_taken, mem_wait;

  logic       st0, fl0, bu0, ww0;
  logic       st1, fl1, bu1, ww1;
  logic       st2, fl2, bu2, ww2;
  logic [1:0] fa0, fb0, fa1, fb1, fa2, fb2;
  logic [4:0] wd0, wd1, wd2;

  always #5 clk = ~clk;

  mips_hazard_unit #(.REG_AW(5), .DELAY_SLOT(1), .FWD_EN(1)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
    .id_load(id_load), .ex_taken(ex_taken), .mem_wait(mem_wait),
    .stall(st0), .flush_id(fl0), .ex_bubble(bu0), .fwd_a(fa0), .fwd_b(fb0),
    .wb_regwr(ww0), .wb_dst(wd0));

  mips_hazard_unit #(.REG_AW(5), .DELAY_SLOT(0), .FWD_EN(1)) u_ds0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
    .id_load(id_load), .ex_taken(ex_taken), .mem_wait(mem_wait),
    .stall(st1), .flush_id(fl1), .ex_bubble(bu1), .fwd_a(fa1), .fwd_b(fb1),
    .wb_regwr(ww1), .wb_dst(wd1));

  mips_hazard_unit #(.REG_AW(5), .DELAY_SLOT(1), .FWD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst), .id_regwr(id_regwr),
    .id_load(id_load), .ex_taken(ex_taken), .mem_wait(mem_wait),
    .stall(st2), .flush_id(fl2), .ex_bubble(bu2), .fwd_a(fa2), .fwd_b(fb2),
    .wb_regwr(ww2), .wb_dst(wd2));

  typedef struct {
    int          sel;
    string       nm;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic string fmt(input logic [12:0] v);
    return $sformatf("stall=%0d flush=%0d bubble=%0d fwd_a=%0d fwd_b=%0d wb_regwr=%0d wb_dst=%0d",
                     v[12], v[11], v[10], v[9:8], v[7:6], v[5], v[4:0]);
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [12:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       act = {st0, fl0, bu0, fa0, fb0, ww0, wd0};
          1:       act = {st1, fl1, bu1, fa1, fb1, ww1, wd1};
          default: act = {st2, fl2, bu2, fa2, fb2, ww2, wd2};
        endcase
        checks++;
        if (act === e.v) passes++;
        else $display("FAIL %s (dut%0d): got %s, required %s", e.nm, e.sel, fmt(act), fmt(e.v));
      end
    end
  end

  task automatic exp_out(input int sel, input string nm, input logic st, input logic fl,
                         input logic bu, input logic [1:0] fa, input logic [1:0] fb,
                         input logic ww, input logic [4:0] wd);
    exp_t e;
    e.sel = sel;
    e.nm  = nm;
    e.v   = {st, fl, bu, fa, fb, ww, wd};
    q.push_back(e);
  endtask

  task automatic exp_zero(input int sel, input string nm);
    exp_out(sel, nm, 0, 0, 0, 2'd0, 2'd0, 0, 5'd0);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic ld);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dst = dst; id_regwr = rw; id_load = ld;
  endtask

  task automatic idle();
    set_id(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_wait = 1'b0; ex_taken = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; mem_wait = 1'b0; ex_taken = 1'b0;
    idle();
    tick();
    for (int s = 0; s < 3; s++) exp_zero(s, "in_reset");
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) exp_zero(s, "after_reset");
    tick();

    // ALU result forwarded from MEM
    set_id(1, 5'd5, 5'd0, 1, 0, 5'd1, 1, 0);      exp_zero(0, "addi_id");       tick();
    set_id(1, 5'd1, 5'd4, 1, 1, 5'd6, 1, 0);      exp_zero(0, "nor_id_nostall"); tick();
    idle(); exp_out(0, "nor_ex_fwd_a_mem", 0, 0, 0, 2'd1, 2'd0, 0, 5'd0);       tick();
    idle(); exp_out(0, "addi_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd1);                tick();
    idle(); exp_out(0, "nor_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd6);                 tick();
    idle(); exp_zero(0, "drain_idle");                                          tick();

    // Load-use: one stall, then WB forward
    set_id(1, 5'd3, 5'd0, 1, 0, 5'd2, 1, 1);      exp_zero(0, "lw_id");         tick();
    set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0);
    exp_out(0, "load_use_stall", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);
    exp_out(1, "load_use_stall_ds0", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);            tick();
    exp_zero(0, "load_use_released");                                           tick();
    idle(); exp_out(0, "subu_ex_fwd_b_wb", 0, 0, 0, 2'd0, 2'd2, 1, 5'd2);       tick();
    idle(); exp_zero(0, "bubble_in_wb");                                        tick();
    idle(); exp_out(0, "subu_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd8);                tick();
    idle(); exp_zero(0, "drain_idle2");                                         tick();

    // Register 0 never hits
    set_id(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0);      exp_zero(0, "addi_r0_id");    tick();
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd9, 1, 0);      exp_zero(0, "r0_reader_id");  tick();
    idle(); exp_zero(0, "r0_reader_ex_nofwd");                                  tick();
    idle(); exp_out(0, "addi_r0_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd0);             tick();
    idle(); exp_out(0, "r0_reader_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd9);           tick();

    // Taken transfer with and without delay slot
    do_reset();
    set_id(1, 5'd3, 5'd0, 1, 0, 5'd2, 1, 1);
    exp_zero(0, "br_lw_id"); exp_zero(1, "br_lw_id_ds0");                       tick();
    set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); ex_taken = 1'b1;
    exp_out(0, "taken_ds1_stall", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);
    exp_out(1, "taken_ds0_flush", 0, 1, 1, 2'd0, 2'd0, 0, 5'd0);               tick();
    idle();
    exp_zero(0, "taken_ds1_ignored");
    exp_out(1, "taken_ds0_flush_only", 0, 1, 1, 2'd0, 2'd0, 0, 5'd0);          tick();
    ex_taken = 1'b0;
    exp_out(0, "br_lw_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd2);
    exp_out(1, "br_lw_wb_ds0", 0, 0, 0, 2'd0, 2'd0, 1, 5'd2);                  tick();

    // No bypass: RAW stalls until the producer leaves WB
    do_reset();
    set_id(1, 5'd5, 5'd0, 1, 0, 5'd3, 1, 0);      exp_zero(2, "nf_addi_id");    tick();
    set_id(1, 5'd3, 5'd0, 1, 0, 5'd10, 1, 0);
    exp_out(2, "nf_raw_ex", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);
    exp_zero(0, "fwd_no_stall");                                                tick();
    exp_out(2, "nf_raw_mem", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);
    exp_out(0, "fwd_reader_ex_a_mem", 0, 0, 0, 2'd1, 2'd0, 0, 5'd0);           tick();
    exp_out(2, "nf_raw_wb", 1, 0, 1, 2'd0, 2'd0, 1, 5'd3);                      tick();
    exp_zero(2, "nf_released");                                                 tick();

    // Memory freeze, then reset during the freeze
    do_reset();
    set_id(1, 5'd5, 5'd0, 1, 0, 5'd1, 1, 0);      exp_zero(0, "mw_addi_id");    tick();
    set_id(1, 5'd1, 5'd4, 1, 1, 5'd6, 1, 0);      exp_zero(0, "mw_nor_id");     tick();
    idle(); mem_wait = 1'b1;
    exp_out(0, "mw_cycle1", 1, 0, 0, 2'd1, 2'd0, 0, 5'd0);                      tick();
    exp_out(0, "mw_cycle2_hold", 1, 0, 0, 2'd1, 2'd0, 0, 5'd0);                 tick();
    rst = 1'b1; exp_zero(0, "mw_cycle3_rst");                                   tick();
    exp_zero(0, "mw_cycle4_rst");                                               tick();
    rst = 1'b0; mem_wait = 1'b0; exp_zero(0, "mw_after_rst");                   tick();

    // Freeze without reset keeps the scoreboard in place
    set_id(1, 5'd5, 5'd0, 1, 0, 5'd1, 1, 0);      exp_zero(0, "mw2_addi_id");   tick();
    set_id(1, 5'd1, 5'd4, 1, 1, 5'd6, 1, 0);      exp_zero(0, "mw2_nor_id");    tick();
    idle(); mem_wait = 1'b1;
    exp_out(0, "mw2_freeze", 1, 0, 0, 2'd1, 2'd0, 0, 5'd0);                     tick();
    mem_wait = 1'b0;
    exp_out(0, "mw2_release_held", 0, 0, 0, 2'd1, 2'd0, 0, 5'd0);               tick();
    exp_out(0, "mw2_addi_wb", 0, 0, 0, 2'd0, 2'd0, 1, 5'd1);                    tick();

    // Load-use held across a freeze is still honoured afterwards
    set_id(1, 5'd3, 5'd0, 1, 0, 5'd2, 1, 1);
    exp_out(0, "mw3_lw_id", 0, 0, 0, 2'd0, 2'd0, 1, 5'd6);                      tick();
    set_id(1, 5'd7, 5'd2, 1, 1, 5'd8, 1, 0); mem_wait = 1'b1;
    exp_out(0, "mw3_freeze_no_bubble", 1, 0, 0, 2'd0, 2'd0, 0, 5'd0);           tick();
    mem_wait = 1'b0;
    exp_out(0, "mw3_load_use_after", 1, 0, 1, 2'd0, 2'd0, 0, 5'd0);             tick();
    exp_zero(0, "mw3_released");                                                tick();

    idle();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL queue_drain: %0d entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mips_hazard_unit.md
Name: mips_hazard_unit

Overview:
- Parametrised pipeline hazard and forwarding controller for the next-generation 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Replaces the fixed per-signal forwarding flags: it keeps its own register-destination scoreboard for the EX, MEM and WB stages.
- Drives the EX operand-bypass selects, load-use and RAW stalls, the control-transfer flush and the global memory-wait freeze.
- Sits beside the control unit; the datapath consumes its selects and stall/flush.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- DELAY_SLOT, 1, 1 = branch/jump delay slot executes; 0 = the instruction in ID is squashed on a taken transfer.
- FWD_EN, 1, 1 = bypass from MEM/WB; 0 = no bypass, stall on any RAW hazard against EX/MEM/WB.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  REG_AW  ID source A address
- id_rt  in  REG_AW  ID source B address
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  REG_AW  ID destination (rd or rt, already muxed)
- id_regwr  in  1  ID instruction writes register file
- id_load  in  1  ID instruction is LW
- ex_taken  in  1  control transfer in EX resolved taken
- mem_wait  in  1  data memory not ready; freezes whole pipe
- stall  out  1  hold PC and IF/ID register
- flush_id  out  1  squash IF/ID contents
- ex_bubble  out  1  datapath loads a NOP into ID/EX
- fwd_a  out  2  EX operand A select: 0 regfile, 1 MEM result, 2 WB result
- fwd_b  out  2  EX operand B select, same encoding
- wb_regwr  out  1  qualified WB write enable (valid and regwr)
- wb_dst  out  REG_AW  WB destination

Behaviour:
- Scoreboard: three entries (EX, MEM, WB), each holding {valid, rs, rt, use_rs, use_rt, dst, regwr, load}. On each non-frozen edge: WB<=MEM, MEM<=EX, and EX<=ID entry, or an invalid entry when ex_bubble=1.
- Reset: all entry valids 0. Outputs: stall=0, flush_id=0, ex_bubble=0, fwd_a=fwd_b=0, wb_regwr=0, wb_dst=0. A reset mid-operation discards all in-flight entries; the same-cycle mem_wait is ignored.
- All outputs are combinational from scoreboard state and current inputs; no added latency.
- Hit(stage, r): stage valid, regwr, dst==r, dst!=0. Register 0 never hits.
- FWD_EN=1:
  - fwd_a = 1 if Hit(MEM, EX.rs) and MEM not load and EX.use_rs; else 2 if Hit(WB, EX.rs) and EX.use_rs; else 0. MEM has priority over WB. fwd_b is computed likewise on rt.
  - Load-use stall when id_valid, EX.load and Hit(EX, id_rs & use_rs, or id_rt & use_rt). The 1-cycle stall places the load in WB when the consumer reaches EX.
- FWD_EN=0:
  - fwd_a=fwd_b=0 always.
  - stall when id_valid and the ID sources hit any of EX, MEM or WB (the register file writes first-half/reads second-half, so a WB hit also stalls only if the regfile lacks write-through; this design stalls on WB).
- Stall: stall=1, ex_bubble=1, flush_id=0.
- Taken transfer:
  - DELAY_SLOT=0 and ex_taken: flush_id=1 and ex_bubble=1 (the ID instruction becomes a bubble); stall is forced to 0, so flush beats stall.
  - DELAY_SLOT=1: ex_taken is ignored and flush_id stays 0.
- mem_wait=1: the scoreboard holds. stall=1, ex_bubble=0, flush_id=0; fwd selects are still driven from the held state. Any pending load-use/flush is re-evaluated after release, and no event is lost.
- Hazards are only evaluated when id_valid=1; an invalid ID never stalls.
- wb_regwr = WB.valid & WB.regwr; wb_dst = WB.dst.

Test Plan:
- Reset, then ADDI r1 (dst 1) followed by NOR using rs=1 -> the consumer in EX sees fwd_a=1 for 1 cycle, stall never asserts.
- LW r2 followed immediately by SUBU using rt=2 (FWD_EN=1) -> stall=1 and ex_bubble=1 for exactly 1 cycle; next cycle the consumer is in EX with fwd_b=2.
- ADDI with dst=0 followed by a reader of r0 -> fwd_a=fwd_b=0, no stall.
- DELAY_SLOT=0, ex_taken=1 while ID holds a load-use-hazard instruction -> flush_id=1, ex_bubble=1, stall=0; DELAY_SLOT=1 with the same stimulus -> flush_id=0 and stall=1.
- FWD_EN=0, ADDI r3 followed by a reader of r3 -> stall high for 3 cycles, fwd always 0.
- mem_wait held for 4 cycles with an ADDI in MEM and its consumer in EX -> fwd_a stays 1 throughout, stall=1; rst asserted in the 3rd wait cycle -> all outputs 0 the next cycle, wb_regwr=0.
